// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode constants (instruction[31:26])
//   - funct codes used as ALU operation selectors (instruction[5:0])
//   - FSM state encoding (values are visible on the State debug port)
//   - instruction class enum plus the helper that derives it from op/funct
//   - packed control vector shared by the decoder and the top level
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Funct codes (jr, and the ALU operations driven on AluOP)
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // FSM states; the numeric values are part of the debug interface.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Instruction classes: every opcode/funct pair maps to exactly one.
    typedef enum logic [3:0] {
        C_RTYPE   = 4'd0,
        C_JR      = 4'd1,
        C_J       = 4'd2,
        C_JAL     = 4'd3,
        C_BEQ     = 4'd4,
        C_BNE     = 4'd5,
        C_IMM     = 4'd6,
        C_LW      = 4'd7,
        C_SW      = 4'd8,
        C_ILLEGAL = 4'd9
    } insn_class_t;

    // Control vector towards the datapath.
    typedef struct packed {
        logic [5:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       jump_reg;
        logic       jump;
        logic       jal;
        logic       and_op;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       immediate;
        logic       reg_write;
        logic       pc_write;
    } ctrl_t;

    // OP_HALT never reaches EXEC (DECODE diverts it), so it falls into
    // the illegal class here.
    function automatic insn_class_t classify(input logic [5:0] op,
                                             input logic [5:0] fn);
        insn_class_t cls;
        case (op)
            OP_RTYPE: cls = (fn == FN_JR) ? C_JR : C_RTYPE;
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            OP_BEQ:   cls = C_BEQ;
            OP_BNE:   cls = C_BNE;
            OP_ADDI,
            OP_SLTI,
            OP_ANDI,
            OP_ORI:   cls = C_IMM;
            OP_LW:    cls = C_LW;
            OP_SW:    cls = C_SW;
            default:  cls = C_ILLEGAL;
        endcase
        return cls;
    endfunction

    // ALU operation for the immediate-arithmetic opcodes.
    function automatic logic [5:0] imm_alu_op(input logic [5:0] op);
        logic [5:0] fn;
        case (op)
            OP_SLTI: fn = FN_SLT;
            OP_ANDI: fn = FN_AND;
            OP_ORI:  fn = FN_OR;
            default: fn = FN_ADD;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational map from (state, latched opcode, latched funct) to the
// datapath control vector. It never looks at live instruction bits, so the
// controls stay stable for the whole instruction once DECODE has latched it.
// The memory-ready qualified PC strobe of sw is added by the top level.
//
// Ports:
//   state  in   current FSM state
//   ir_op  in   latched opcode
//   ir_fn  in   latched funct
//   ctrl   out  control vector (all zero for states not driving anything)
// -----------------------------------------------------------------------------
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] ir_op,
    input  logic [5:0] ir_fn,
    output ctrl_t      ctrl
);

    insn_class_t cls;

    always_comb begin
        ctrl = '0;
        cls  = classify(ir_op, ir_fn);
        case (state)
            S_EXEC: begin
                case (cls)
                    C_RTYPE: ctrl.alu_op = ir_fn;
                    C_JR: begin
                        ctrl.jump_reg = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    C_J: begin
                        ctrl.jump     = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    C_JAL: begin
                        ctrl.jump      = 1'b1;
                        ctrl.jal       = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.pc_write  = 1'b1;
                    end
                    C_BEQ, C_BNE: begin
                        // Branch selects the inverted Zero polarity for bne.
                        ctrl.and_op   = 1'b1;
                        ctrl.branch   = (cls == C_BNE);
                        ctrl.alu_op   = FN_SUB;
                        ctrl.pc_write = 1'b1;
                    end
                    C_IMM: begin
                        ctrl.immediate = 1'b1;
                        ctrl.alu_op    = imm_alu_op(ir_op);
                    end
                    C_LW, C_SW: begin
                        ctrl.immediate = 1'b1;
                        ctrl.alu_op    = FN_ADD;
                    end
                    default: begin
                        // Illegal opcode: retire as a NOP.
                        ctrl.pc_write = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Address computation stays selected while memory works.
                ctrl.alu_op    = FN_ADD;
                ctrl.mem_read  = (cls == C_LW);
                ctrl.mem_write = (cls == C_SW);
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_write  = 1'b1;
                case (cls)
                    C_RTYPE: begin
                        ctrl.reg_dst = 1'b1;
                        ctrl.alu_op  = ir_fn;
                    end
                    C_IMM: begin
                        ctrl.immediate = 1'b1;
                        ctrl.alu_op    = imm_alu_op(ir_op);
                    end
                    C_LW: begin
                        ctrl.mem_to_reg = 1'b1;
                        ctrl.alu_op     = FN_ADD;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle FSM controller for the 32-bit MIPS process unit. Latches the
// instruction fields in DECODE, sequences FETCH/DECODE/EXEC/MEM/WB, issues one
// PcWrite strobe per retired instruction, counts retirements and halts on the
// halt opcode or on a data-memory timeout.
//
// Memory handshake: in MEM, MemRead/MemWrite stay high until the cycle in which
// MemReady is sampled high; that cycle completes the access. If MemReady has
// not arrived by the MEM_TIMEOUT-th MEM cycle, the unit sets Fault and halts.
//
// Ports:
//   Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//   OpCode, Funct     live instruction fields, sampled only in DECODE
//   MemReady          data memory completes the access this cycle
//   AluOP .. RegWrite datapath controls
//   PcWrite           one-cycle PC update strobe per instruction
//   Halted            unit is in HALT
//   Fault             sticky: illegal opcode or memory timeout
//   Retired           instructions retired (wraps)
//   State             current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255   // must be >= 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic [5:0]       AluOP,
    output logic             RegDst,
    output logic             Branch,
    output logic             JumpReg,
    output logic             Jump,
    output logic             Jal,
    output logic             And,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             MemWrite,
    output logic             Immediate,
    output logic             RegWrite,
    output logic             PcWrite,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] Retired,
    output logic [2:0]       State
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [5:0]        ir_op;
    logic [5:0]        ir_fn;
    logic [WAIT_W-1:0] wait_cnt;   // MEM cycles already spent, 0 on entry
    logic              fault_set;
    logic              sw_done;
    insn_class_t       cls;
    ctrl_t             ctrl;

    assign cls = classify(ir_op, ir_fn);

    ctrl_decode u_decode (
        .state (state),
        .ir_op (ir_op),
        .ir_fn (ir_fn),
        .ctrl  (ctrl)
    );

    // The store retires in the same cycle memory accepts it.
    assign sw_done = (state == S_MEM) && (cls == C_SW) && MemReady;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        fault_set = 1'b0;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            // The halt check is the only decision taken from live inputs.
            S_DECODE: state_nx = (OpCode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_RTYPE, C_IMM: state_nx = S_WB;
                    C_LW, C_SW:     state_nx = S_MEM;
                    C_ILLEGAL: begin
                        fault_set = 1'b1;
                        state_nx  = S_FETCH;
                    end
                    default:        state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (MemReady) begin
                    state_nx = (cls == C_LW) ? S_WB : S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_set = 1'b1;
                    state_nx  = S_HALT;
                end
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // ------------------------------------------- IR latch, wait counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ir_op    <= '0;
            ir_fn    <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir_op <= OpCode;
                ir_fn <= Funct;
            end
            if (state == S_MEM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // ------------------------------------- retirement counter, fault flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Retired <= '0;
            Fault   <= 1'b0;
        end else begin
            if (PcWrite) begin
                Retired <= Retired + 1'b1;
            end
            if (fault_set) begin
                Fault <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- outputs
    assign AluOP     = ctrl.alu_op;
    assign RegDst    = ctrl.reg_dst;
    assign Branch    = ctrl.branch;
    assign JumpReg   = ctrl.jump_reg;
    assign Jump      = ctrl.jump;
    assign Jal       = ctrl.jal;
    assign And       = ctrl.and_op;
    assign MemRead   = ctrl.mem_read;
    assign MemToReg  = ctrl.mem_to_reg;
    assign MemWrite  = ctrl.mem_write;
    assign Immediate = ctrl.immediate;
    assign RegWrite  = ctrl.reg_write;
    assign PcWrite   = ctrl.pc_write | sw_done;
    assign Halted    = (state == S_HALT);
    assign State     = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench: a per-instruction behavioural model pushes the expected
// output vector for every cycle into exp_q; one compare process checks the DUT
// on each falling edge. Literal checks pin latencies and counters.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int CNT_W = 32;
    localparam int TO    = 255;
    localparam int EW    = 3 + 6 + 12 + 2 + CNT_W;

    // Flag bit order: RegDst Branch JumpReg Jump Jal And MemRead MemToReg
    //                 MemWrite Immediate RegWrite PcWrite
    localparam logic [11:0] F_NONE = 12'h000;
    localparam logic [11:0] F_RD   = 12'h800;
    localparam logic [11:0] F_BR   = 12'h400;
    localparam logic [11:0] F_JR   = 12'h200;
    localparam logic [11:0] F_J    = 12'h100;
    localparam logic [11:0] F_JAL  = 12'h080;
    localparam logic [11:0] F_AND  = 12'h040;
    localparam logic [11:0] F_MRD  = 12'h020;
    localparam logic [11:0] F_M2R  = 12'h010;
    localparam logic [11:0] F_MWR  = 12'h008;
    localparam logic [11:0] F_IMM  = 12'h004;
    localparam logic [11:0] F_RW   = 12'h002;
    localparam logic [11:0] F_PC   = 12'h001;

    logic             Clk;
    logic             Rst_n;
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             MemReady;
    logic [5:0]       AluOP;
    logic             RegDst, Branch, JumpReg, Jump, Jal, And;
    logic             MemRead, MemToReg, MemWrite, Immediate, RegWrite;
    logic             PcWrite, Halted, Fault;
    logic [CNT_W-1:0] Retired;
    logic [2:0]       State;

    multicycle_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .OpCode(OpCode), .Funct(Funct),
        .MemReady(MemReady), .AluOP(AluOP), .RegDst(RegDst), .Branch(Branch),
        .JumpReg(JumpReg), .Jump(Jump), .Jal(Jal), .And(And),
        .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .Immediate(Immediate), .RegWrite(RegWrite), .PcWrite(PcWrite),
        .Halted(Halted), .Fault(Fault), .Retired(Retired), .State(State)
    );

    // ------------------------------------------------ clock / watchdog
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ scoreboard
    logic [EW-1:0]    exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic             m_fault;
    logic [CNT_W-1:0] m_retired;

    always @(negedge Clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {State, AluOP, RegDst, Branch, JumpReg, Jump, Jal, And,
                 MemRead, MemToReg, MemWrite, Immediate, RegWrite, PcWrite,
                 Halted, Fault, Retired};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // --------------------------------------------------------- drivers
    // Called at posedge+1: drive this cycle's inputs, record what the
    // outputs must be during this cycle, then advance to the next posedge+1.
    task automatic cyc(input logic [2:0] st, input logic [5:0] alu, input logic [11:0] fl,
                       input logic [5:0] op_in, input logic [5:0] fn_in, input logic rdy);
        OpCode   = op_in;
        Funct    = fn_in;
        MemReady = rdy;
        exp_q.push_back({st, alu, fl, (st == 3'd5), m_fault, m_retired});
        if (fl[0]) m_retired = m_retired + 1'b1;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [5:0] imm_fn(input logic [5:0] op);
        case (op)
            6'h0A:   return 6'h2A;
            6'h0C:   return 6'h24;
            6'h0D:   return 6'h25;
            default: return 6'h20;
        endcase
    endfunction

    // One instruction from FETCH to retirement (or into HALT). w is the
    // number of MEM cycles with MemReady low before it rises.
    task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input int w,
                            output int ncyc);
        logic [11:0] fl;
        logic        rdy;
        ncyc = 2;
        cyc(3'd0, 6'h00, F_NONE, rnd6(), rnd6(), rnd1());
        cyc(3'd1, 6'h00, F_NONE, op, fn, rnd1());
        if (op == 6'h3F) return;
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    cyc(3'd2, 6'h00, F_JR | F_PC, rnd6(), rnd6(), rnd1());
                    ncyc += 1;
                end else begin
                    cyc(3'd2, fn, F_NONE, rnd6(), rnd6(), rnd1());
                    cyc(3'd4, fn, F_RD | F_RW | F_PC, rnd6(), rnd6(), rnd1());
                    ncyc += 2;
                end
            end
            6'h02: begin cyc(3'd2, 6'h00, F_J | F_PC, rnd6(), rnd6(), rnd1()); ncyc += 1; end
            6'h03: begin cyc(3'd2, 6'h00, F_J | F_JAL | F_RW | F_PC, rnd6(), rnd6(), rnd1()); ncyc += 1; end
            6'h04: begin cyc(3'd2, 6'h22, F_AND | F_PC, rnd6(), rnd6(), rnd1()); ncyc += 1; end
            6'h05: begin cyc(3'd2, 6'h22, F_AND | F_BR | F_PC, rnd6(), rnd6(), rnd1()); ncyc += 1; end
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                cyc(3'd2, imm_fn(op), F_IMM, rnd6(), rnd6(), rnd1());
                cyc(3'd4, imm_fn(op), F_IMM | F_RW | F_PC, rnd6(), rnd6(), rnd1());
                ncyc += 2;
            end
            6'h23, 6'h2B: begin
                cyc(3'd2, 6'h20, F_IMM, rnd6(), rnd6(), rnd1());
                ncyc += 1;
                for (int i = 0; i < TO; i++) begin
                    rdy = (i >= w);
                    fl  = (op == 6'h23) ? F_MRD : F_MWR;
                    if (rdy && op == 6'h2B) fl = fl | F_PC;
                    cyc(3'd3, 6'h20, fl, rnd6(), rnd6(), rdy);
                    ncyc += 1;
                    if (rdy) begin
                        if (op == 6'h23) begin
                            cyc(3'd4, 6'h20, F_M2R | F_RW | F_PC, rnd6(), rnd6(), rnd1());
                            ncyc += 1;
                        end
                        break;
                    end
                    if (i == TO - 1) m_fault = 1'b1;   // timed out into HALT
                end
            end
            default: begin
                cyc(3'd2, 6'h00, F_PC, rnd6(), rnd6(), rnd1());
                m_fault = 1'b1;
                ncyc += 1;
            end
        endcase
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(3'd5, 6'h00, F_NONE, rnd6(), rnd6(), rnd1());
    endtask

    // Leaves the bench at posedge+1 of a FETCH cycle.
    task automatic do_reset();
        Rst_n    = 1'b0;
        OpCode   = '0;
        Funct    = '0;
        MemReady = 1'b0;
        m_fault   = 1'b0;
        m_retired = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    // --------------------------------------------------------- stimulus
    logic [5:0] op_tbl[16];
    int         nc;
    logic [5:0] op;
    logic [5:0] fn;

    initial begin
        op_tbl = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                   6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h23, 6'h2B, 6'h3E};

        // Reset state, checked while reset is held.
        Rst_n = 1'b0; OpCode = '0; Funct = '0; MemReady = 1'b0;
        m_fault = 1'b0; m_retired = '0;
        @(posedge Clk); #1;
        chk("reset_state", State, 0);
        chk("reset_retired", Retired, 0);
        chk("reset_fault", Fault, 0);
        chk("reset_controls", {AluOP, PcWrite, RegWrite, MemRead, MemWrite, Halted}, 0);
        do_reset();

        // R-type add.
        run_insn(6'h00, 6'h20, 0, nc);
        chk("rtype_latency", nc, 4);
        chk("rtype_retired", Retired, 1);

        // lw with three wait cycles.
        run_insn(6'h23, 6'h00, 3, nc);
        chk("lw_latency", nc, 8);
        chk("lw_retired", Retired, 2);

        // sw with immediate ready.
        run_insn(6'h2B, 6'h00, 0, nc);
        chk("sw_latency", nc, 4);

        // beq, bne, jal.
        do_reset();
        run_insn(6'h04, rnd6(), 0, nc); chk("beq_latency", nc, 3);
        run_insn(6'h05, rnd6(), 0, nc); chk("bne_latency", nc, 3);
        run_insn(6'h03, rnd6(), 0, nc); chk("jal_latency", nc, 3);
        chk("branch_group_retired", Retired, 3);

        // Randomized instruction stream.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            op = op_tbl[$urandom_range(0, 15)];
            fn = rnd6();
            if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
            run_insn(op, fn, $urandom_range(0, 5), nc);
        end
        chk("random_retired", Retired, m_retired);

        // Illegal opcode, then halt.
        do_reset();
        run_insn(6'h3E, 6'h00, 0, nc);
        chk("illegal_latency", nc, 3);
        chk("illegal_fault", Fault, 1);
        chk("illegal_retired", Retired, 1);
        run_insn(6'h3F, 6'h00, 0, nc);
        halt_cycles(20);
        chk("halt_halted", Halted, 1);
        chk("halt_state", State, 5);
        chk("halt_retired", Retired, 1);

        // Memory timeout on sw.
        do_reset();
        run_insn(6'h2B, 6'h00, 100000, nc);
        chk("timeout_latency", nc, 3 + TO);
        halt_cycles(3);
        chk("timeout_fault", Fault, 1);
        chk("timeout_state", State, 5);

        // Asynchronous reset in the middle of a store's MEM phase.
        do_reset();
        run_insn(6'h00, 6'h25, 0, nc);
        cyc(3'd0, 6'h00, F_NONE, rnd6(), rnd6(), 1'b0);
        cyc(3'd1, 6'h00, F_NONE, 6'h2B, rnd6(), 1'b0);
        cyc(3'd2, 6'h20, F_IMM, rnd6(), rnd6(), 1'b0);
        cyc(3'd3, 6'h20, F_MWR, rnd6(), rnd6(), 1'b0);
        chk("mid_mem_write", MemWrite, 1);
        chk("mid_mem_retired", Retired, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_memwrite", MemWrite, 0);
        chk("async_rst_state", State, 0);
        chk("async_rst_retired", Retired, 0);
        m_fault = 1'b0; m_retired = '0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        run_insn(6'h08, 6'h00, 0, nc);
        chk("post_reset_retired", Retired, 1);

        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
